// File: rtl/sample_player_if.sv
// Bus bundle for sample_player: memory write port, playback control and the
// sample stream that feeds fir_filter.data_in.
interface sample_player_if #(
   parameter int N     = 16,
   parameter int AW    = 5,
   parameter int DIV_W = 8
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [N-1:0]     wr_data;
   logic             start;
   logic             stop;
   logic [AW-1:0]    length;
   logic [DIV_W-1:0] rate_div;
   logic [N-1:0]     sample_out;
   logic             sample_valid;
   logic             busy;
   logic             done;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, length, rate_div,
      input  sample_out, sample_valid, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, length, rate_div,
      output sample_out, sample_valid, busy, done
   );
endinterface

// File: rtl/sample_player.sv
// Programmable sample source: 2^AW x N memory replayed at a divided rate with a
// zero-order hold. Define SAMPLE_PLAYER_LOOP_EN to loop playback instead of one-shot.
module sample_player #(
   parameter int N     = 16,
   parameter int AW    = 5,
   parameter int DIV_W = 8
) (
   input logic            clk,
   input logic            reset,
   sample_player_if.slave bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PLAY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [AW-1:0]    len_q, len_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [N-1:0]     sampleOut_q, sampleOut_d;
   logic             sampleValid_q, sampleValid_d;
   logic             done_q, done_d;
   logic [N-1:0]     mem_q [0:(1<<AW)-1];
   logic             tick;

   assign tick = (cnt_q == div_q);

   // Next-state logic; stop has priority over a tick so an aborted run emits nothing
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      div_d         = div_q;
      sampleOut_d   = sampleOut_q;
      sampleValid_d = 1'b0;
      done_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = PLAY;
               addr_d  = '0;
               cnt_d   = '0;
               len_d   = bus.length;
               div_d   = bus.rate_div;
            end
         end
         PLAY: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (tick) begin
               sampleOut_d   = mem_q[addr_q];
               sampleValid_d = 1'b1;
               cnt_d         = '0;
               if (addr_q == len_q) begin
                  done_d = 1'b1;
                  addr_d = '0;
`ifdef SAMPLE_PLAYER_LOOP_EN
                  state_d = PLAY;
`else
                  state_d = IDLE;
`endif
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         div_q         <= '0;
         sampleOut_q   <= '0;
         sampleValid_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         div_q         <= div_d;
         sampleOut_q   <= sampleOut_d;
         sampleValid_q <= sampleValid_d;
         done_q        <= done_d;
      end
   end

   // Memory survives reset; writes are accepted only while idle
   always_ff @(posedge clk) begin
      if (state_q == IDLE && bus.wr_en) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.sample_out   = sampleOut_q;
   assign bus.sample_valid = sampleValid_q;
   assign bus.busy         = (state_q == PLAY);
   assign bus.done         = done_q;

endmodule

// File: tb/tb_sample_player.sv
// Scoreboard bench for sample_player: the stimulus side predicts every sample
// (cycle, value, done) into a queue; a negedge monitor pops and compares.
module tb_sample_player;

   localparam int N     = 16;
   localparam int AW    = 5;
   localparam int DIV_W = 8;
`ifdef SAMPLE_PLAYER_LOOP_EN
   localparam bit LoopMode = 1'b1;
`else
   localparam bit LoopMode = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [N-1:0] data;
      logic       done;
   } expT;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   sample_player_if #(.N(N), .AW(AW), .DIV_W(DIV_W)) spIf ();

   sample_player #(.N(N), .AW(AW), .DIV_W(DIV_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (spIf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Reference model state
   logic [N-1:0] memM [0:(1<<AW)-1];
   expT          expQ [$];
   int           busyFrom   = 0;
   int           busyUntil  = 0;
   logic [N-1:0] expHold    = '0;
   bit           checkEn    = 1'b0;
   int           vectors    = 0;
   int           miscompares = 0;
   logic         expValid, expDone;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: one comparison set per cycle, away from the rising edge
   always @(negedge clk) begin
      if (checkEn) begin
         while (expQ.size() > 0 && expQ[0].cyc < cyc) void'(expQ.pop_front());
         expValid = (expQ.size() > 0) && (expQ[0].cyc == cyc);
         expDone  = 1'b0;
         checkOutput("sample_valid", {31'b0, spIf.sample_valid}, {31'b0, expValid});
         if (expValid) begin
            expHold = expQ[0].data;
            expDone = expQ[0].done;
            void'(expQ.pop_front());
         end
         checkOutput("sample_out", {16'b0, spIf.sample_out}, {16'b0, expHold});
         checkOutput("done", {31'b0, spIf.done}, {31'b0, expDone});
         checkOutput("busy", {31'b0, spIf.busy}, {31'b0, (cyc >= busyFrom && cyc < busyUntil)});
      end
   end

   // All stimulus tasks are entered and left 1 time unit after a rising edge
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input bit we, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                                input bit st, input bit sp, input logic [AW-1:0] ln,
                                input logic [DIV_W-1:0] dv);
      bit  idleNow;
      int  nS;
      int  period;
      int  span;
      expT e;
      idleNow       = !(cyc >= busyFrom && cyc < busyUntil);
      spIf.wr_en    = we;
      spIf.wr_addr  = wa;
      spIf.wr_data  = wd;
      spIf.start    = st;
      spIf.stop     = sp;
      spIf.length   = ln;
      spIf.rate_div = dv;
      if (idleNow && we) memM[wa] = wd;
      if (idleNow && st && !sp) begin
         period = int'(dv) + 1;
         span   = int'(ln) + 1;
         nS     = LoopMode ? 200 : span;
         for (int j = 0; j < nS; j++) begin
            e.cyc  = cyc + 1 + (j + 1) * period;
            e.data = memM[j % span];
            e.done = ((j % span) == int'(ln));
            expQ.push_back(e);
         end
         busyFrom  = cyc + 1;
         busyUntil = LoopMode ? 32'h7fff_ffff : cyc + 1 + span * period;
      end
      @(posedge clk);
      #1;
      if (!idleNow && sp) begin
         expQ.delete();
         busyUntil = cyc;
      end
      spIf.wr_en = 1'b0;
      spIf.start = 1'b0;
      spIf.stop  = 1'b0;
   endtask

   task automatic applyReset(input int n);
      reset = 1'b1;
      @(posedge clk);
      #1;
      expQ.delete();
      expHold = '0;
      if (busyUntil > cyc) busyUntil = cyc;
      repeat (n - 1) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic writeMem(input logic [AW-1:0] a, input logic [N-1:0] d);
      applyStimulus(1'b1, a, d, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic startPlay(input logic [AW-1:0] ln, input logic [DIV_W-1:0] dv);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, ln, dv);
   endtask

   task automatic stopPlay();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, '0, '0);
   endtask

   task automatic runPlay(input logic [AW-1:0] ln, input logic [DIV_W-1:0] dv, input int waitN);
      startPlay(ln, dv);
      idle(waitN);
      stopPlay();
   endtask

   initial begin
      spIf.wr_en    = 1'b0;
      spIf.wr_addr  = '0;
      spIf.wr_data  = '0;
      spIf.start    = 1'b0;
      spIf.stop     = 1'b0;
      spIf.length   = '0;
      spIf.rate_div = '0;
      @(posedge clk);
      #1;
      applyReset(2);
      checkEn = 1'b1;

      for (int i = 0; i < 32; i++) writeMem(5'(i), 16'(3 * i));

      runPlay(5'd3, 8'd0, 6);
      idle(2);
      runPlay(5'd1, 8'd2, 8);
      idle(2);

      // Stop right after addr 7 while a write to addr 10 is attempted mid-play
      startPlay(5'd31, 8'd0);
      applyStimulus(1'b1, 5'd10, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      idle(7);
      stopPlay();
      idle(3);
      runPlay(5'd10, 8'd0, 14);
      idle(2);

      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 5'd5, 8'd0);
      idle(3);
      applyStimulus(1'b1, 5'd0, 16'h1234, 1'b1, 1'b0, 5'd0, 8'd0);
      idle(3);
      stopPlay();
      writeMem(5'd0, 16'd0);

      // Reset in the middle of a run must leave the memory intact
      startPlay(5'd31, 8'd1);
      idle(9);
      applyReset(2);
      idle(2);
      runPlay(5'd5, 8'd0, 8);
      idle(2);

      runPlay(5'd31, 8'd0, 70);
      idle(3);

      for (int it = 0; it < 25; it++) begin
         int ln;
         int dv;
         int dur;
         ln  = int'($urandom_range(0, 7));
         dv  = int'($urandom_range(0, 3));
         dur = (ln + 1) * (dv + 1);
         repeat ($urandom_range(0, 3)) writeMem(5'($urandom_range(0, 31)), 16'($urandom));
         startPlay(5'(ln), 8'(dv));
         if ($urandom_range(0, 1) == 1)
            applyStimulus(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 1'b1, 1'b0,
                          5'($urandom_range(0, 31)), 8'($urandom_range(0, 7)));
         idle(int'($urandom_range(0, dur + 2)));
         stopPlay();
         idle(2);
      end

      idle(3);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sample_player.md
# sample_player

Programmable sample source that streams a stored test signal into the `fir_filter` `data_in` port. It holds a writable 32×16 sample memory and plays addresses 0..`length` at a programmable rate, with a zero-order hold between samples, because the filter consumes a sample on every clock. It sits directly upstream of `fir_filter` and replaces file-loaded stimulus with a synthesizable, run-time reloadable source.

## Interface
Parameters:
- `N`, 16, sample width; matches `fir_filter` data width.
- `AW`, 5, address width; memory depth is 2^`AW` (32).
- `DIV_W`, 8, width of the rate divider.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: memory write strobe; honoured only in IDLE.
- `wr_addr` in `AW`: write address.
- `wr_data` in `N`: write data.
- `start` in 1: begin playback; honoured only in IDLE.
- `stop` in 1: abort playback; honoured only in PLAY.
- `length` in `AW`: last address played, inclusive; latched when `start` is accepted.
- `rate_div` in `DIV_W`: one sample every `rate_div`+1 cycles; latched when `start` is accepted.
- `sample_out` out `N`: current sample; connects to `fir_filter.data_in`.
- `sample_valid` out 1: one-cycle pulse when `sample_out` takes a new value.
- `busy` out 1: high while in PLAY.
- `done` out 1: one-cycle pulse, coincident with the `sample_valid` of the sample at address `length`.

## Operation
- FSM has two states, IDLE and PLAY. `busy` = (state == PLAY), registered.
- Internal registers:
  - `addr` (`AW` bits)
  - `cnt` (`DIV_W` bits)
  - latched `len_q`
  - latched `div_q`
- IDLE, `start`=1 and `stop`=0: next state is PLAY; `addr`←0, `cnt`←0; latch `length` and `rate_div`.
- PLAY, each cycle:
  - If `stop`=1: next state is IDLE, no sample is emitted, `sample_out` holds.
  - Else if `cnt` == `div_q` (tick):
    - `sample_out`←mem[`addr`], `sample_valid`←1, `cnt`←0.
    - If `addr` == `len_q`: `done`←1 and the end action applies (see Configuration).
    - Otherwise `addr`←`addr`+1.
  - Else: `cnt`←`cnt`+1, and `sample_out` holds its value.
- Writes: in IDLE, `wr_en`=1 writes mem[`wr_addr`]←`wr_data` on the edge. In PLAY, writes are dropped silently.
- `wr_en` and `start` in the same IDLE cycle: both take effect. The first read happens at least one cycle later, so it sees the new data.
- `start` and `stop` asserted together in IDLE: `start` is ignored.
- `start` while in PLAY: ignored; the latched `len_q` and `div_q` are unchanged.
- `length`=0: plays the single sample mem[0].
- Address arithmetic is modulo 2^`AW`; wrap 31→0 happens only through the end action.

## Timing
- Reset (synchronous): state IDLE; `sample_out`=0, `sample_valid`=0, `busy`=0, `done`=0; `addr`=0, `cnt`=0. Memory contents are not cleared.
- `start` sampled at edge E0: `busy`=1 after E0.
  - The first `sample_valid` is high after edge E0+`rate_div`+1.
  - With `rate_div`=0, `sample_valid` is high on the second cycle after `start` is asserted.
- Sample spacing is exactly `rate_div`+1 cycles, with no gap at the `length` boundary in loop mode.
- `sample_out` is stable between valid pulses. The filter may sample it on every cycle.
- `stop` sampled at edge Es: `busy`=0 after Es, and no `sample_valid` or `done` occurs at Es.
- One-shot end: the `done` edge also sets the state to IDLE, so `busy` falls together with the `done` pulse.
- A new `start` is accepted on the first cycle after `busy` falls.

## Configuration
- `SAMPLE_PLAYER_LOOP_EN` defined:
  - End action is `addr`←0 and the block stays in PLAY.
  - `done` pulses once per pass.
  - Playback continues until `stop` or `reset`.
- Macro undefined: end action is one-shot; next state is IDLE and `addr`←0.

## Test plan
- Reset: assert `reset` for 2 cycles mid-playback → next cycle `sample_out`=0 and `sample_valid`/`busy`/`done`=0. mem[5] still reads back its prior value on a later playback.
- One-shot: load mem[i]=3·i, `length`=3, `rate_div`=0, pulse `start` → `sample_valid` on 4 consecutive cycles carrying 0, 3, 6, 9. `done` coincides with 9. `busy` falls with `done`, and `sample_out` holds 9 afterwards.
- Rate divider: `length`=1, `rate_div`=2 → valid pulses 3 cycles apart carrying 0, then 3. `sample_out` is held for 3 cycles each.
- Stop and write protection:
  - `length`=31, `rate_div`=0. Assert `wr_en` to mem[10]=0xFFFF during PLAY, then `stop` after the sample from addr 7.
  - Expect no further valid pulses and `sample_out`=21.
  - Replay: addr 10 yields 30, not 0xFFFF.
- Simultaneous events:
  - `start`+`stop` in IDLE → `busy` stays 0.
  - `wr_en`(addr 0=0x1234)+`start` in the same cycle → first sample is 0x1234.
- With `SAMPLE_PLAYER_LOOP_EN`: `length`=31, `rate_div`=0 → addr 31 (93) is followed the next cycle by addr 0 (0). `done` pulses every 32 cycles and `busy` stays high until `stop`.
